// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Includes a 2-flop input synchroniser, start-bit glitch rejection, and framing/parity error pulses.
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_done,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);
  localparam int BI_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_MID   = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_FULL  = TC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [TC_W-1:0]       tc;
  logic [BI_W-1:0]       bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                  perr_lat;
`endif

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  // Divider is held at zero while idle so its phase starts at the detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          div_cnt <= '0;
    else if (state == S_IDLE || tick) div_cnt <= '0;
    else                              div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick    = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tc        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_lat   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low each cycle and are set only on the stop-bit sample, giving 1-clk pulses.
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            tc      <= '0;
            bit_idx <= '0;
          end
        end

        S_START: begin
          if (tick) begin
            if (tc == TC_MID) begin
              tc    <= '0;
              state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tc <= tc + TC_W'(1);
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (tc == TC_FULL) begin
              tc    <= '0;
              shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
              if (bit_idx == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + BI_W'(1);
              end
            end else begin
              tc <= tc + TC_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            if (tc == TC_FULL) begin
              tc       <= '0;
              perr_lat <= rx_s ^ (^shreg);
              state    <= S_STOP;
            end else begin
              tc <= tc + TC_W'(1);
            end
          end
        end
`endif

        S_STOP: begin
          if (tick) begin
            if (tc == TC_FULL) begin
              tc <= '0;
              if (rx_s) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= perr_lat;
`endif
                state   <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              tc <= tc + TC_W'(1);
            end
          end
        end

        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus pushes expected strobes, a negedge monitor pops and compares.
// Frame format follows UART_RX_PARITY_EN when it is defined for the compile.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 250_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx_os #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         last_done_cyc = 0;
  int         last_gap = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (rx_done || frame_err || parity_err)) begin
      if (rx_done) begin
        check("done_width", {31'b0, prev_done}, 32'd0);
        last_gap      = cyc - last_done_cyc;
        last_done_cyc = cyc;
        done_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'b0, rx_done, frame_err, parity_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {30'b0, rx_done, frame_err}, e.ferr ? 32'd1 : 32'd2);
        check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        check("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
      end
    end
    prev_done = rx_done;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_clks, input logic par, input logic stop);
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, bit_clks);
`endif
    drive_bit(stop, bit_clks);
    rx = 1'b1;
  endtask

  task automatic expect_good(input logic [7:0] d, input logic perr);
    exp_t e;
    e.ferr = 1'b0;
    e.data = d;
    e.perr = perr;
    sb.push_back(e);
    last_good = d;
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.ferr = 1'b1;
    e.data = last_good;
    e.perr = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int f0;
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    check("reset_outputs", {21'b0, rx_data, rx_done, rx_busy, frame_err, parity_err}, 32'd0);
    rst = 1'b0;
    idle(2 * BIT_CLKS);

    // 1: reset in the middle of a frame, then a clean 0xA5
    d0 = done_cnt;
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 2);
    check("busy_before_abort", {31'b0, rx_busy}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("reset_midframe_outputs", {21'b0, rx_data, rx_done, rx_busy, frame_err, parity_err}, 32'd0);
    rx = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(2 * BIT_CLKS);
    check("idle_after_abort", {31'b0, rx_busy}, 32'd0);
    expect_good(8'hA5, 1'b0);
    send_frame(8'hA5, BIT_CLKS, 1'b0, 1'b1);
    drain("drain_a5");
    check("a5_done_count", done_cnt - d0, 32'd1);

    // 2: back-to-back frames, no idle gap
    idle(BIT_CLKS);
    d0 = done_cnt;
    expect_good(8'h00, 1'b0);
    expect_good(8'hFF, 1'b0);
    expect_good(8'h3C, 1'b0);
    send_frame(8'h00, BIT_CLKS, 1'b0, 1'b1);
    send_frame(8'hFF, BIT_CLKS, 1'b0, 1'b1);
    send_frame(8'h3C, BIT_CLKS, 1'b0, 1'b1);
    drain("drain_b2b");
    check("b2b_done_count", done_cnt - d0, 32'd3);
    check("b2b_spacing", last_gap, FRAME_BITS * BIT_CLKS);

    // 3: start glitch shorter than half a bit
    idle(BIT_CLKS);
    d0 = done_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    idle(6);
    check("glitch_busy_rise", {31'b0, rx_busy}, 32'd1);
    idle(14);
    rx = 1'b1;
    idle(60);
    check("glitch_busy_fall", {31'b0, rx_busy}, 32'd0);
    check("glitch_no_strobe", (done_cnt - d0) + (ferr_cnt - f0), 32'd0);

    // 4: stop bit low, line held in break, then recovery with 0x81
    idle(BIT_CLKS);
    f0 = ferr_cnt;
    expect_ferr();
    send_frame(8'h55, BIT_CLKS, 1'b0, 1'b0);
    rx = 1'b0;
    idle(3 * BIT_CLKS);
    check("break_busy", {31'b0, rx_busy}, 32'd1);
    check("break_ferr_count", ferr_cnt - f0, 32'd1);
    rx = 1'b1;
    idle(5);
    check("break_release", {31'b0, rx_busy}, 32'd0);
    idle(BIT_CLKS);
    expect_good(8'h81, 1'b0);
    send_frame(8'h81, BIT_CLKS, 1'b0, 1'b1);
    drain("drain_81");

    // 5: baud skew, kept inside the receiver's sampling tolerance for the whole frame
    idle(BIT_CLKS);
    expect_good(8'h96, 1'b0);
    send_frame(8'h96, 62, 1'b0, 1'b1);
    idle(2 * BIT_CLKS);
    expect_good(8'h96, 1'b0);
    send_frame(8'h96, 66, 1'b0, 1'b1);
    drain("drain_skew");

`ifdef UART_RX_PARITY_EN
    // 6: correct and wrong even parity on 0x07
    idle(BIT_CLKS);
    expect_good(8'h07, 1'b0);
    send_frame(8'h07, BIT_CLKS, 1'b1, 1'b1);
    idle(BIT_CLKS);
    expect_good(8'h07, 1'b1);
    send_frame(8'h07, BIT_CLKS, 1'b0, 1'b1);
    drain("drain_parity");
`endif

    idle(2 * BIT_CLKS);
    check("final_idle", {31'b0, rx_busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
